// File: rtl/regfile_write_buffer.sv
// Write-side buffer for the 32x32 register file: in-order FIFO of pending writes,
// drained one per cycle to the write port, with two read-bypass lookups.
module regfile_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       drain_hold,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  input  logic [ADDR_W-1:0]          lk_addr_a,
  output logic                       lk_hit_a,
  output logic [DATA_W-1:0]          lk_data_a,
  input  logic [ADDR_W-1:0]          lk_addr_b,
  output logic                       lk_hit_b,
  output logic [DATA_W-1:0]          lk_data_b,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     cnt;
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic              push;
  logic              pop;
  logic [PW-1:0]     idx;

  assign count    = cnt;
  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign in_ready = !full && !reset;
  assign wr_en    = !empty && !drain_hold && !reset;
  assign wr_addr  = empty ? '0 : addr_q[head];
  assign wr_data  = empty ? '0 : data_q[head];

  // Writes to register 0 complete the handshake but are never stored.
  assign push = in_valid && in_ready && (in_addr != '0);
  assign pop  = wr_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= in_addr;
      data_q[tail] <= in_data;
    end
  end

  // Walk oldest to youngest from head so a later match overrides an earlier one.
  always_comb begin
    lk_hit_a  = 1'b0;
    lk_data_a = '0;
    lk_hit_b  = 1'b0;
    lk_data_b = '0;
    idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (!reset && valid_q[idx] && (lk_addr_a != '0) && (addr_q[idx] == lk_addr_a)) begin
        lk_hit_a  = 1'b1;
        lk_data_a = data_q[idx];
      end
      if (!reset && valid_q[idx] && (lk_addr_b != '0) && (addr_q[idx] == lk_addr_b)) begin
        lk_hit_b  = 1'b1;
        lk_data_b = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Directed bench for regfile_write_buffer: queue-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_regfile_write_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              drain_hold;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] lk_addr_a;
  logic              lk_hit_a;
  logic [DATA_W-1:0] lk_data_a;
  logic [ADDR_W-1:0] lk_addr_b;
  logic              lk_hit_b;
  logic [DATA_W-1:0] lk_data_b;
  logic [2:0]        count;
  logic              empty;
  logic              full;

  regfile_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .drain_hold(drain_hold),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lk_addr_a(lk_addr_a), .lk_hit_a(lk_hit_a), .lk_data_a(lk_data_a),
    .lk_addr_b(lk_addr_b), .lk_hit_b(lk_hit_b), .lk_data_b(lk_data_b),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit mdl_on    = 1'b0;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;
  ent_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
  endtask

  // Reference model: a plain list of pending writes, oldest first.
  always @(posedge clk) begin
    if (reset) q.delete();
    else begin
      automatic bit do_push = in_valid && (q.size() < DEPTH) && (in_addr != 0);
      if (q.size() > 0 && !drain_hold) void'(q.pop_front());
      if (do_push) q.push_back({in_addr, in_data});
    end
  end

  function automatic logic [32:0] ref_lookup(input logic [ADDR_W-1:0] a);
    if (reset || a == 0) return '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a == a) return {1'b1, q[i].d};
    return '0;
  endfunction

  always @(negedge clk) begin
    if (mdl_on) begin
      automatic logic [32:0] ra = ref_lookup(lk_addr_a);
      automatic logic [32:0] rb = ref_lookup(lk_addr_b);
      automatic int n = q.size();
      chk("m_count",    32'(count),    32'(n));
      chk("m_empty",    32'(empty),    32'(n == 0));
      chk("m_full",     32'(full),     32'(n == DEPTH));
      chk("m_in_ready", 32'(in_ready), 32'(n < DEPTH && !reset));
      chk("m_wr_en",    32'(wr_en),    32'(n > 0 && !drain_hold && !reset));
      chk("m_wr_addr",  32'(wr_addr),  (n > 0) ? 32'(q[0].a) : 32'd0);
      chk("m_wr_data",  wr_data,       (n > 0) ? q[0].d : 32'd0);
      chk("m_hit_a",    32'(lk_hit_a), 32'(ra[32]));
      chk("m_data_a",   lk_data_a,     ra[31:0]);
      chk("m_hit_b",    32'(lk_hit_b), 32'(rb[32]));
      chk("m_data_b",   lk_data_b,     rb[31:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    in_valid = 1'b1; in_addr = a; in_data = d;
    tick();
    in_valid = 1'b0; in_addr = '0; in_data = '0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    drain_hold = 1'b0; lk_addr_a = '0; lk_addr_b = '0;
    tick();
    mdl_on = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    tick();

    // Single write, one-cycle drain latency.
    push1(5'd2, 32'd42);
    @(negedge clk);
    chk("one_count", 32'(count), 32'd1);
    chk("one_wr_en", 32'(wr_en), 32'd1);
    chk("one_wr_addr", 32'(wr_addr), 32'd2);
    chk("one_wr_data", wr_data, 32'd42);
    tick();
    @(negedge clk);
    chk("one_empty", 32'(empty), 32'd1);

    // Bypass lookups with duplicate addresses.
    drain_hold = 1'b1;
    push1(5'd3, 32'd10);
    push1(5'd3, 32'd20);
    push1(5'd5, 32'd7);
    lk_addr_a = 5'd3; lk_addr_b = 5'd5;
    @(negedge clk);
    chk("byp_count", 32'(count), 32'd3);
    chk("byp_hit_a", 32'(lk_hit_a), 32'd1);
    chk("byp_data_a", lk_data_a, 32'd20);
    chk("byp_data_b", lk_data_b, 32'd7);
    chk("byp_hold_wr_en", 32'(wr_en), 32'd0);
    #1 lk_addr_a = 5'd4;
    #1 chk("byp_miss_hit", 32'(lk_hit_a), 32'd0);
    chk("byp_miss_data", lk_data_a, 32'd0);
    tick();

    // Fill to full, hold a fifth request, then drain in order.
    push1(5'd9, 32'd99);
    @(negedge clk);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b1; in_addr = 5'd6; in_data = 32'd66;
    tick(); tick();
    @(negedge clk);
    chk("full_hold_count", 32'(count), 32'd4);
    chk("full_hold_a", lk_data_a, 32'd0);
    tick();
    in_valid = 1'b0; in_addr = '0; in_data = '0;
    drain_hold = 1'b0;
    begin
      logic [ADDR_W-1:0] ea [4];
      logic [DATA_W-1:0] ed [4];
      ea[0] = 5'd3; ea[1] = 5'd3; ea[2] = 5'd5; ea[3] = 5'd9;
      ed[0] = 32'd10; ed[1] = 32'd20; ed[2] = 32'd7; ed[3] = 32'd99;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("drain_wr_en", 32'(wr_en), 32'd1);
        chk("drain_addr", 32'(wr_addr), 32'(ea[i]));
        chk("drain_data", wr_data, ed[i]);
        tick();
      end
    end
    @(negedge clk);
    chk("drain_empty", 32'(empty), 32'd1);
    tick();

    // Register 0 writes are accepted and dropped.
    lk_addr_a = 5'd0; lk_addr_b = 5'd0;
    in_valid = 1'b1; in_addr = 5'd0; in_data = 32'd12;
    @(negedge clk);
    chk("zero_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    chk("zero_count", 32'(count), 32'd0);
    chk("zero_wr_en", 32'(wr_en), 32'd0);
    chk("zero_hit", 32'(lk_hit_a), 32'd0);
    tick();

    // Steady push/pop at count 2 with pointer wrap.
    drain_hold = 1'b1;
    push1(5'd1, 32'd101);
    push1(5'd2, 32'd102);
    drain_hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_addr = ADDR_W'(i + 3); in_data = 32'(200 + i);
      @(negedge clk);
      chk("steady_count", 32'(count), 32'd2);
      chk("steady_addr", 32'(wr_addr), 32'(i + 1));
      tick();
    end
    in_valid = 1'b0; in_addr = '0; in_data = '0;
    tick(); tick();
    @(negedge clk);
    chk("steady_empty", 32'(empty), 32'd1);
    tick();

    // Reset discards pending writes.
    drain_hold = 1'b1;
    push1(5'd7, 32'd70);
    push1(5'd8, 32'd80);
    push1(5'd7, 32'd71);
    lk_addr_a = 5'd7; lk_addr_b = 5'd8;
    @(negedge clk);
    chk("pre_rst_data_a", lk_data_a, 32'd71);
    tick();
    reset = 1'b1; drain_hold = 1'b0;
    @(negedge clk);
    chk("in_rst_wr_en", 32'(wr_en), 32'd0);
    chk("in_rst_hit_a", 32'(lk_hit_a), 32'd0);
    chk("in_rst_hit_b", 32'(lk_hit_b), 32'd0);
    chk("in_rst_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_wr_en", 32'(wr_en), 32'd0);
      chk("post_rst_empty", 32'(empty), 32'd1);
      tick();
    end

    mdl_on = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
